// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: opcodes, controller states and flag bundle.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_ADC  = 4'h5,
        OP_SBB  = 4'h6,
        OP_CMP  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_ASR  = 4'hA,
        OP_ROL  = 4'hB,
        OP_ROR  = 4'hC,
        OP_MUL  = 4'hD,
        OP_MULH = 4'hE,
        OP_NOT  = 4'hF
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } alu_flags_t;

    function automatic logic is_mul_op(input alu_op_e op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial-product step per cycle, N steps.
module alu_mul_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0]  count;
    logic [N-1:0]   mcand;
    logic [2*N-1:0] acc;
    logic [N:0]     sum;
    logic [2*N-1:0] acc_next;

    // Upper half accumulates the multiplicand, lower half holds the multiplier bits still to consume.
    always_comb begin
        sum      = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_next = {sum, acc[N-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            mcand <= '0;
            acc   <= '0;
        end else if (start) begin
            count <= CW'(N);
            mcand <= a;
            acc   <= {{N{1'b0}}, b};
        end else if (busy) begin
            count <= count - 1'b1;
            acc   <= acc_next;
        end
    end

    // product is the post-step value, so the consumer can commit it on the same edge as the final step.
    assign busy    = (count != '0);
    assign done    = (count == CW'(1));
    assign product = acc_next;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked N-bit ALU with sticky flags and a multi-cycle multiplier.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int N   = 8,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   mode,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         flag_zero,
    output logic         flag_carry,
    output logic         flag_neg,
    output logic         flag_ovf
);
    alu_state_e     state;
    alu_flags_t     flags;
    logic           hi_sel;
    alu_op_e        op;
    logic           accept;
    logic           mul_start, mul_busy, mul_done;
    logic [2*N-1:0] mul_product;
    logic [N-1:0]   mul_res;

    logic [N-1:0]   res;
    logic           c_next, v_next;
    logic [31:0]    amt;
    logic [N:0]     add_w, sub_w, shl_w, shr_w;
    logic signed [N:0] asr_w;

    assign op        = alu_op_e'(mode);
    assign in_ready  = rst_n && (state == IDLE) && !mul_busy && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_mul_op(op);
    assign mul_res   = hi_sel ? mul_product[2*N-1:N] : mul_product[N-1:0];

    alu_mul_seq #(.N(N)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        amt    = 32'(in_b[SHW-1:0]) % 32'(N);
        add_w  = {1'b0, in_a} + {1'b0, in_b} + {{N{1'b0}}, (op == OP_ADC) && flags.c};
        sub_w  = {1'b0, in_a} - {1'b0, in_b} - {{N{1'b0}}, (op == OP_SBB) && flags.c};
        // Guard bit catches the last bit shifted out; it stays 0 for a zero amount.
        shl_w  = {1'b0, in_a} << amt;
        shr_w  = {in_a, 1'b0} >> amt;
        asr_w  = $signed({in_a, 1'b0}) >>> amt;
        res    = '0;
        c_next = 1'b0;
        v_next = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                res    = add_w[N-1:0];
                c_next = add_w[N];
                v_next = (in_a[N-1] == in_b[N-1]) && (add_w[N-1] != in_a[N-1]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                res    = sub_w[N-1:0];
                c_next = sub_w[N];
                v_next = (in_a[N-1] != in_b[N-1]) && (sub_w[N-1] != in_a[N-1]);
            end
            OP_AND: res = in_a & in_b;
            OP_OR:  res = in_a | in_b;
            OP_XOR: res = in_a ^ in_b;
            OP_NOT: res = ~in_a;
            OP_SHL: begin
                res    = shl_w[N-1:0];
                c_next = shl_w[N];
            end
            OP_SHR: begin
                res    = shr_w[N:1];
                c_next = shr_w[0];
            end
            OP_ASR: begin
                res    = asr_w[N:1];
                c_next = asr_w[0];
            end
            OP_ROL: res = (in_a << amt) | (in_a >> (32'(N) - amt));
            OP_ROR: res = (in_a >> amt) | (in_a << (32'(N) - amt));
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            flags     <= '0;
            hi_sel    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_mul_op(op)) begin
                        state     <= MUL;
                        hi_sel    <= (op == OP_MULH);
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        out_valid <= 1'b1;
                        if (op != OP_CMP) out <= res;
                        flags <= '{z: (res == '0), c: c_next, n: res[N-1], v: v_next};
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state     <= IDLE;
                        out       <= mul_res;
                        out_valid <= 1'b1;
                        flags     <= '{z: (mul_res == '0), c: (mul_product[2*N-1:N] != '0),
                                       n: mul_res[N-1], v: 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign flag_zero  = flags.z;
    assign flag_carry = flags.c;
    assign flag_neg   = flags.n;
    assign flag_ovf   = flags.v;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the 8-bit datapath ALU. Width is generic; adds sticky flags, carry-chained ADC/SBB, shifts/rotates and a multi-cycle multiplier.
- Sits between the decode/register-read stage and writeback.
- Valid/ready on both sides, so multi-cycle ops and writeback stalls are absorbed without dropping operations.

Parameters:
- N, 8: operand/result width in bits (>=4).
- SHW, $clog2(N): width of the shift-amount field taken from in_b[SHW-1:0] (derived; do not override).

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation this cycle.
- mode  input  4  opcode (alu_pkg encoding).
- in_a  input  N  operand A.
- in_b  input  N  operand B / shift amount.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer takes the result this cycle.
- out  output  N  result register.
- flag_zero  output  1  sticky Z.
- flag_carry  output  1  sticky C.
- flag_neg  output  1  sticky N (result MSB).
- flag_ovf  output  1  sticky V (signed overflow).

Behaviour:
- Reset (async assert, sync-safe deassert via clk): state=IDLE, out=0, out_valid=0, all flags=0. in_ready=0 while rst_n low.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready), so accept and consume may coincide.
  - out/out_valid hold stable while out_valid && !out_ready.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADC (a+b+C), 6 SBB (a-b-C).
  - 7 CMP: SUB flags only; out unchanged, out_valid still pulses.
  - 8 SHL, 9 SHR, A ASR, B ROL, C ROR.
  - D MUL (low half), E MULH (high half, unsigned), F NOT (~a).
- Arithmetic:
  - {C,res} = N+1-bit add/sub, zero-extended. SUB/SBB/CMP C=1 means borrow.
  - V = signed overflow: ADD-type: a,b same sign and res sign differs. SUB-type: a,b signs differ and res sign != a sign.
  - Logic/NOT: C=0, V=0.
- Shifts:
  - amount = in_b[SHW-1:0]; wraps modulo N.
  - C = last bit shifted out; C=0 when amount is 0. Rotates set C=0. V=0.
- Flags:
  - Z, N computed from the committed result.
  - All four flags update in the same cycle out_valid rises, never on accept.
  - ADC/SBB read C as it stands at accept. Back-to-back accept reads the C committed by the previous op.
- Single-cycle ops: IDLE; accept -> result/flags registered at that edge; out_valid=1 next cycle. Latency 1, throughput 1/cycle with out_ready=1.
- MUL/MULH state machine:
  - IDLE -> MUL on accept. Operands are latched and the counter is loaded with N.
  - MUL: one shift-add step per cycle. After N steps go to IDLE with the 2N-bit product complete; out = low or high half; out_valid=1. Latency N+1.
  - Flags: C = (high half != 0). V=0. Z/N from the selected half.
  - in_ready=0 throughout MUL.
- Undefined width/op cases do not exist: all 16 codes are defined; no X ever driven.
- Reset mid-MUL: abort immediately; no result, flags cleared.
- out_ready with out_valid=0 is ignored.

Decomposition:
- alu_pkg holds:
  - opcode localparams/enum alu_op_e: OP_ADD..OP_NOT, 4-bit.
  - state enum alu_state_e {IDLE, MUL}.
  - struct alu_flags_t {z,c,n,v}.
- Sub-module alu_mul_seq (parametrised N): start, a, b, busy, done, product[2N-1:0]; owns counter and shift-add. alu_pipe instantiates it once.

Test Plan:
- ADD a=0xFF, b=0x01 (N=8), out_ready=1 -> next cycle out=0x00, out_valid=1, Z=1 C=1 N=0 V=0.
- ADD 0x7F+0x01 -> out=0x80, V=1 N=1 C=0. Then SUB 0x00-0x01 -> out=0xFF, C=1 (borrow), N=1, V=0.
- Carry chain: ADD 0xFF+0x01 (C=1), then back-to-back ADC 0x00+0x00 -> out=0x01, C=0, Z=0.
- MUL a=0xFF, b=0xFF:
  - in_ready low for 8 cycles; out=0x01 at cycle 9, C=1.
  - MULH same operands -> out=0xFE.
  - MUL 0x0F*0x11 -> 0xFF, C=0.
- Shifts: SHR 0x81 by 1 -> out=0x40, C=1. ROL 0x81 by 1 -> 0x03, C=0. SHL amount b=0x09 wraps to 1.
- Backpressure/reset:
  - Hold out_ready=0 for 3 cycles after a result -> out/flags stable, in_ready=0.
  - Assert rst_n=0 mid-MUL -> out_valid=0, flags=0 immediately; first op after release completes normally.
